dmem_access_ctrl: RTL

- MEM-stage data-memory controller. Consumes the registered EX/MEM outputs: store enable, writeback select, byte-strobe width and store data, plus address and valid.
- Sequences each load/store onto a req/gnt/rvalid data-memory port. Aligns strobes and data to the doubleword lane, sign- or zero-extends load data, and stalls the pipeline (holds EX/MEM and earlier stages) until the access completes.

---
 rtl/dmem_access_ctrl_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_access_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_access_ctrl_pkg
// Brief  : Shared encodings for the MEM-stage data-memory controller.
// Rev    : 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic strb_is_legal(input logic [7:0] strb);
        return (strb == STRB_B) || (strb == STRB_H) ||
               (strb == STRB_W) || (strb == STRB_D);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane_align
// Brief  : Byte-lane legality check, store strobe/data shift, load extract.
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [7:0]      strb,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] store_data,
    output logic            legal,
    output logic [7:0]      strb_shifted,
    output logic [XLEN-1:0] store_data_shifted,
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      ld_offset,
    input  logic [7:0]      ld_width,
    input  logic            ld_unsigned,
    output logic [XLEN-1:0] ld_data
);

    logic [15:0]     w_strb_wide;
    logic [5:0]      w_st_shamt;
    logic [5:0]      w_ld_shamt;
    logic [XLEN-1:0] w_rshift;

    // Any strobe bit pushed past lane 7 means the access straddles a doubleword.
    assign w_strb_wide        = {8'h00, strb} << offset;
    assign legal              = strb_is_legal(strb) && (w_strb_wide[15:8] == 8'h00);
    assign strb_shifted       = w_strb_wide[7:0];
    assign w_st_shamt         = {offset, 3'b000};
    assign store_data_shifted = store_data << w_st_shamt;

    assign w_ld_shamt = {ld_offset, 3'b000};
    assign w_rshift   = rdata >> w_ld_shamt;

    always_comb begin
        ld_data = w_rshift;
        case (ld_width)
            STRB_B:  ld_data = {{(XLEN-8){~ld_unsigned & w_rshift[7]}},   w_rshift[7:0]};
            STRB_H:  ld_data = {{(XLEN-16){~ld_unsigned & w_rshift[15]}}, w_rshift[15:0]};
            STRB_W:  ld_data = {{(XLEN-32){~ld_unsigned & w_rshift[31]}}, w_rshift[31:0]};
            default: ld_data = w_rshift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_access_ctrl
// Brief  : MEM-stage load/store sequencer onto a req/gnt/rvalid memory port.
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            mem_valid,
    input  logic            mem_is_write_dmem,
    input  logic [1:0]      mem_wb_select,
    input  logic [7:0]      mem_write_width,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_dmem_write_data,
    input  logic            mem_load_unsigned,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [7:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] mem_load_data,
    output logic            mem_load_valid,
    output logic            mem_err
);

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cnt;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [7:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_ld_off;
    logic [7:0]      r_ld_width;
    logic            r_ld_uns;
    logic [XLEN-1:0] r_load_data;

    logic            w_is_store;
    logic            w_is_load;
    logic            w_access;
    logic            w_legal;
    logic            w_tmo;
    logic            w_start;
    logic [7:0]      w_strb_sh;
    logic [XLEN-1:0] w_wdata_sh;
    logic [XLEN-1:0] w_ld_ext;

    assign w_is_store = mem_is_write_dmem;
    assign w_is_load  = !mem_is_write_dmem && (mem_wb_select == WB_LOAD);
    assign w_access   = mem_valid && (w_is_store || w_is_load);
    assign w_tmo      = (r_cnt == c_TMO_LAST);
    assign w_start    = (r_state == ST_IDLE) && w_access && w_legal;

    dmem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .strb               (mem_write_width),
        .offset             (mem_addr[2:0]),
        .store_data         (mem_dmem_write_data),
        .legal              (w_legal),
        .strb_shifted       (w_strb_sh),
        .store_data_shifted (w_wdata_sh),
        .rdata              (dmem_rdata),
        .ld_offset          (r_ld_off),
        .ld_width           (r_ld_width),
        .ld_unsigned        (r_ld_uns),
        .ld_data            (w_ld_ext)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A timeout in REQ wins over a same-cycle gnt because the request is
    // already withdrawn in that cycle; in WAIT a last-cycle rvalid still lands.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_next = w_legal ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                if (w_tmo) begin
                    w_next = ST_ERR;
                end else if (dmem_gnt) begin
                    w_next = r_we ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    w_next = ST_DONE;
                end else if (w_tmo) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt       <= 8'h00;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= 8'h00;
            r_wdata     <= '0;
            r_ld_off    <= 3'b000;
            r_ld_width  <= 8'h00;
            r_ld_uns    <= 1'b0;
            r_load_data <= '0;
        end else begin
            if (w_start) begin
                r_we       <= w_is_store;
                r_addr     <= {mem_addr[XLEN-1:3], 3'b000};
                r_wstrb    <= w_strb_sh;
                r_wdata    <= w_wdata_sh;
                r_ld_off   <= mem_addr[2:0];
                r_ld_width <= mem_write_width;
                r_ld_uns   <= mem_load_unsigned;
            end

            if ((w_next == ST_REQ && r_state != ST_REQ) ||
                (w_next == ST_WAIT && r_state != ST_WAIT)) begin
                r_cnt <= 8'h00;
            end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == ST_WAIT && dmem_rvalid) begin
                r_load_data <= w_ld_ext;
            end else if (w_next == ST_ERR) begin
                r_load_data <= '0;
            end
        end
    end

    assign dmem_req       = (r_state == ST_REQ) && !w_tmo;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wstrb     = r_wstrb;
    assign dmem_wdata     = r_wdata;
    assign mem_stall      = w_access && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign mem_load_data  = r_load_data;
    assign mem_load_valid = (r_state == ST_DONE) && !r_we;
    assign mem_err        = (r_state == ST_ERR);

endmodule
`default_nettype wire
